pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_hazard_detect.sv | 21 ++
 rtl/pipeline_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding and the
// NOP word loaded into flushed latches.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } pipe_state_t;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use hazard compare between the EX-stage load and the
// source registers of the instruction in ID.
module pipe_hazard_detect #(
  parameter int unsigned REG_W = 4
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic             memread,
  input  logic [REG_W-1:0] rd,
  output logic             hazard
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  always_comb begin
    hazard = memread && (rd != '0) &&
             ((rs_used && (rs == rd)) || (rt_used && (rt == rd)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/halt controller (RUN, DWAIT, HALT).
// Optional performance counters enabled by defining PIPELINE_CTRL_PERF_CNT_EN.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_rs_used,
  input  logic             ifid_rt_used,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             br_taken,
  input  logic             hlt_id,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             halted
);

  pipe_state_t state, next_state;
  logic        ret_halt, ret_halt_next;
  logic        hazard;
  logic        eval_halt;

  pipe_hazard_detect #(.REG_W(REG_W)) u_hazard (
    .rs      (ifid_rs),
    .rt      (ifid_rt),
    .rs_used (ifid_rs_used),
    .rt_used (ifid_rt_used),
    .memread (idex_memread),
    .rd      (idex_rd),
    .hazard  (hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      ret_halt <= 1'b0;
    end else begin
      state    <= next_state;
      ret_halt <= ret_halt_next;
    end
  end

  // DWAIT resumes by behaving exactly like the saved state on its release cycle.
  always_comb begin
    eval_halt     = (state == HALT) || ((state == DWAIT) && ret_halt);
    next_state    = state;
    ret_halt_next = ret_halt;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    halted        = 1'b0;
    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      next_state  = RUN;
    end else if (dcache_miss) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      halted     = eval_halt;
      next_state = DWAIT;
      if (state != DWAIT) ret_halt_next = (state == HALT);
    end else if (eval_halt) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      halted      = 1'b1;
      next_state  = HALT;
    end else begin
      next_state = RUN;
      if (hazard) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (hlt_id) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
        next_state  = HALT;
      end else if (br_taken) begin
        if_id_flush = 1'b1;
      end else if (icache_miss) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != HALT) && !pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if ((state == RUN) && if_id_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random
// stimulus compared against a cycle-level behavioural reference model.
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ifid_rs, ifid_rt, idex_rd;
  logic       ifid_rs_used, ifid_rt_used, idex_memread;
  logic       br_taken, hlt_id, icache_miss, dcache_miss;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, halted;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_halt = 0, m_wait = 0, m_ret_halt = 0;
  int m_stall = 0, m_flush = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REG_W(4), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_rs_used (ifid_rs_used),
    .ifid_rt_used (ifid_rt_used),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .br_taken     (br_taken),
    .hlt_id       (hlt_id),
    .icache_miss  (icache_miss),
    .dcache_miss  (dcache_miss),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .halted       (halted)
  );

  function automatic logic [7:0] obs_vec();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, halted};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs, bit order {pc,ifid,idex,exmem,memwb,ifid_fl,idex_fl,halted}
  function automatic logic [7:0] model_out();
    bit hz, eh;
    hz = idex_memread && idex_rd != 0 &&
         ((ifid_rs_used && ifid_rs == idex_rd) || (ifid_rt_used && ifid_rt == idex_rd));
    eh = m_wait ? m_ret_halt : m_halt;
    if (rst)          return 8'b00000_11_0;
    if (dcache_miss)  return {5'b00000, 2'b00, eh};
    if (eh)           return 8'b01111_10_1;
    if (hz)           return 8'b00011_01_0;
    if (hlt_id)       return 8'b01111_10_0;
    if (br_taken)     return 8'b11111_10_0;
    if (icache_miss)  return 8'b01111_10_0;
    return 8'b11111_00_0;
  endfunction

  task automatic model_advance(input logic [7:0] e);
    bit eh;
    if (rst) begin
      m_halt = 0; m_wait = 0; m_ret_halt = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (!m_halt && !e[7] && m_stall != CMAX) m_stall++;
    if (!m_halt && !m_wait && e[2] && m_flush != CMAX) m_flush++;
    eh = m_wait ? m_ret_halt : m_halt;
    if (dcache_miss) begin
      if (!m_wait) m_ret_halt = m_halt;
      m_wait = 1; m_halt = 0;
    end else begin
      m_wait = 0;
      m_halt = eh || (e == 8'b01111_10_0 && hlt_id && !(idex_memread && idex_rd != 0 &&
               ((ifid_rs_used && ifid_rs == idex_rd) || (ifid_rt_used && ifid_rt == idex_rd))));
    end
  endtask

  // Check combinational outputs for the current inputs, then clock one edge.
  task automatic step(input string tag);
    logic [7:0] e;
    #1;
    e = model_out();
    check(tag, {24'h0, obs_vec()}, {24'h0, e});
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
`endif
    model_advance(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; ifid_rs = 0; ifid_rt = 0; idex_rd = 0;
    ifid_rs_used = 0; ifid_rt_used = 0; idex_memread = 0;
    br_taken = 0; hlt_id = 0; icache_miss = 0; dcache_miss = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    step("reset");
    #1 check("reset_const", {24'h0, obs_vec()}, 32'h06);
    rst = 0;
    step("run_idle");

    // load-use stall then release
    idex_memread = 1; idex_rd = 3; ifid_rs = 3; ifid_rs_used = 1;
    #1 check("hazard_pc_ifid_idexfl", {29'h0, pc_en, if_id_en, id_ex_flush}, 32'b001);
    step("hazard");
    idex_memread = 0;
    step("hazard_release");
    #1 check("hazard_release_en", {27'h0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 32'h1f);

    // rd = 0 never stalls
    idex_memread = 1; idex_rd = 0; ifid_rs = 0;
    step("rd_zero");
    idle();

    // branch beats icache miss
    br_taken = 1; icache_miss = 1;
    #1 check("br_over_icm", {30'h0, pc_en, if_id_flush}, 32'b11);
    step("br_icm");
    br_taken = 0;
    step("icm_only");
    idle();

    // dcache freeze with hazard underneath
    idex_memread = 1; idex_rd = 5; ifid_rt = 5; ifid_rt_used = 1; dcache_miss = 1;
    for (int i = 0; i < 3; i++) step("dmiss_freeze");
    dcache_miss = 0;
    step("dmiss_then_hazard");
    idle();

    // halt, dcache freeze in halt, reset out
    hlt_id = 1;
    step("hlt_enter");
    hlt_id = 0;
    for (int i = 0; i < 10; i++) step("halt_hold");
    #1 check("halted_flag", {31'h0, halted}, 32'h1);
    dcache_miss = 1;
    step("halt_dmiss1");
    step("halt_dmiss2");
    dcache_miss = 0;
    step("halt_return");
    step("halt_again");
    rst = 1;
    step("halt_reset");
    rst = 0;
    step("after_reset");
    #1 check("after_reset_halted", {31'h0, halted}, 32'h0);

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    rst = 1; step("cnt_reset"); rst = 0;
    idex_memread = 1; idex_rd = 2; ifid_rs = 2; ifid_rs_used = 1;
    step("cnt_haz1"); step("cnt_haz2");
    idle(); br_taken = 1; step("cnt_br");
    br_taken = 0;
    #1 check("cnt_stall_2", 32'(stall_cnt), 32'd2);
    check("cnt_flush_1", 32'(flush_cnt), 32'd1);
    icache_miss = 1;
    for (int i = 0; i < 20; i++) step("cnt_sat");
    check("cnt_stall_sat", 32'(stall_cnt), 32'(CMAX));
    check("cnt_flush_sat", 32'(flush_cnt), 32'(CMAX));
    idle();
`endif

    // random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(99) < 2);
      dcache_miss  = ($urandom_range(99) < 12);
      hlt_id       = ($urandom_range(99) < 3);
      br_taken     = ($urandom_range(99) < 20);
      icache_miss  = ($urandom_range(99) < 20);
      idex_memread = ($urandom_range(99) < 40);
      idex_rd      = 4'($urandom_range(3));
      ifid_rs      = 4'($urandom_range(3));
      ifid_rt      = 4'($urandom_range(3));
      ifid_rs_used = 1'($urandom_range(1));
      ifid_rt_used = 1'($urandom_range(1));
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
